sensor_reg_seq: RTL and testbench

- Table-driven power-up and register-load sequencer for I2C/SCCB image sensors; next generation of the fixed-table camera initialiser.
- Generates the PWDN and RESET timing, then steps through an external ROM of command words: register write, millisecond delay, read-poll, end.
- Issues every transaction through the existing i2c_control request/done interface, retries on NACK, and reports completion or failure.
- Supports re-initialisation on request (for example on a resolution change) without a global reset.

---
 rtl/sensor_seq_pkg.sv | 48 ++++
 rtl/sensor_reg_seq_timer.sv | 51 +++++
 rtl/sensor_reg_seq.sv | 195 +++++++++++++++++++
 tb/tb_sensor_reg_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_seq_pkg.sv
`default_nettype none
// ============================================================================
// sensor_seq_pkg : command-word layout, opcodes and FSM states of the sequencer
// Rev 1.0
// ============================================================================
package sensor_seq_pkg;

    localparam int CMD_W   = 34;
    localparam int OP_HI   = 33;
    localparam int OP_LO   = 32;
    localparam int ADDR_HI = 31;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 8;
    localparam int MASK_HI = 7;
    localparam int MASK_LO = 0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_POLL  = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_PWDN   = 4'd0,
        S_RST    = 4'd1,
        S_BOOT   = 4'd2,
        S_FETCH  = 4'd3,
        S_DECODE = 4'd4,
        S_REQ    = 4'd5,
        S_WAIT   = 4'd6,
        S_DLY    = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_reg_seq_timer.sv
`default_nettype none
// ============================================================================
// seq_timer : loadable down-counter with done flag and nested millisecond prescaler
// Rev 1.0
// ============================================================================
module seq_timer #(
    parameter int TW       = 20,
    parameter int MS_CYC   = 50000,
    parameter int INIT_CYC = 65536
)(
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          i_load,
    input  logic          i_ms_mode,
    input  logic [TW-1:0] i_cyc_val,
    input  logic [15:0]   i_ms_val,
    output logic          o_done
);

    localparam logic [TW-1:0] c_MS_RELOAD = TW'(MS_CYC - 1);
    localparam logic [TW-1:0] c_INIT      = TW'(INIT_CYC - 1);

    logic [TW-1:0] r_cnt;
    logic [15:0]   r_ms;

    // A load of N keeps the caller in its state for exactly N clocks;
    // in ms mode r_cnt is the per-millisecond prescaler and r_ms the outer count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= c_INIT;
            r_ms  <= '0;
        end else if (i_load) begin
            if (i_ms_mode) begin
                r_cnt <= (i_ms_val == 16'd0) ? '0 : c_MS_RELOAD;
                r_ms  <= (i_ms_val == 16'd0) ? '0 : i_ms_val - 16'd1;
            end else begin
                r_cnt <= (i_cyc_val == '0) ? '0 : i_cyc_val - 1'b1;
                r_ms  <= '0;
            end
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (r_ms != '0) begin
            r_ms  <= r_ms - 16'd1;
            r_cnt <= c_MS_RELOAD;
        end
    end

    assign o_done = (r_cnt == '0) && (r_ms == '0);

endmodule
`default_nettype wire

// File: rtl/sensor_reg_seq.sv
`default_nettype none
// ============================================================================
// sensor_reg_seq : table-driven power-up and register-load sequencer for I2C/SCCB sensors
// Rev 1.0
// ============================================================================
module sensor_reg_seq
    import sensor_seq_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = 8'h78,
    parameter bit         ADDR16    = 1'b1,
    parameter int         ROM_AW    = 8,
    parameter int         PWDN_CYC  = 65536,
    parameter int         RST_CYC   = 50176,
    parameter int         BOOT_CYC  = 1000000,
    parameter int         MS_CYC    = 50000,
    parameter int         MAX_RETRY = 3,
    parameter int         POLL_MAX  = 255
)(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    output logic              camera_pwdn,
    output logic              camera_rst_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [CMD_W-1:0]  rom_q,
    output logic              wrreg_req,
    output logic              rdreg_req,
    output logic              addr_mode,
    output logic [7:0]        device_id,
    output logic [15:0]       reg_addr,
    output logic [7:0]        wrdata,
    input  logic [7:0]        rddata,
    input  logic              RW_Done,
    input  logic              ack,
    output logic              Init_Done,
    output logic              Init_Err,
    output logic [ROM_AW-1:0] err_index
);

    localparam int c_TW = $clog2(max4(PWDN_CYC, RST_CYC, BOOT_CYC, MS_CYC) + 1);
    localparam int c_RW = $clog2(MAX_RETRY + 2);
    localparam int c_PW = $clog2(POLL_MAX + 1);

    localparam logic [c_TW-1:0] c_PWDN_VAL   = c_TW'(PWDN_CYC);
    localparam logic [c_TW-1:0] c_RST_VAL    = c_TW'(RST_CYC);
    localparam logic [c_TW-1:0] c_BOOT_VAL   = c_TW'(BOOT_CYC);
    localparam logic [c_RW-1:0] c_RETRY_LAST = c_RW'(MAX_RETRY);
    localparam logic [c_PW-1:0] c_POLL_LAST  = c_PW'(POLL_MAX - 1);

    state_e            r_state, w_state_nxt;
    op_e               r_op;
    logic [ROM_AW-1:0] r_rom_addr, r_err_index;
    logic [15:0]       r_reg_addr;
    logic [7:0]        r_data, r_mask;
    logic [c_RW-1:0]   r_retry;
    logic [c_PW-1:0]   r_poll;

    logic              w_tmr_load, w_tmr_ms, w_tmr_done;
    logic [c_TW-1:0]   w_tmr_cyc;
    logic              w_advance, w_retry_inc, w_poll_inc, w_match;
    logic [15:0]       w_dec_addr;

    assign w_match    = ((rddata & r_mask) == (r_data & r_mask));
    assign w_dec_addr = ADDR16 ? rom_q[ADDR_HI:ADDR_LO] : {8'h00, rom_q[ADDR_LO+7:ADDR_LO]};

    seq_timer #(
        .TW       (c_TW),
        .MS_CYC   (MS_CYC),
        .INIT_CYC (PWDN_CYC)
    ) u_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_load    (w_tmr_load),
        .i_ms_mode (w_tmr_ms),
        .i_cyc_val (w_tmr_cyc),
        .i_ms_val  ({rom_q[DATA_HI:DATA_LO], rom_q[MASK_HI:MASK_LO]}),
        .o_done    (w_tmr_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_ms    = 1'b0;
        w_tmr_cyc   = '0;
        w_advance   = 1'b0;
        w_retry_inc = 1'b0;
        w_poll_inc  = 1'b0;
        case (r_state)
            S_PWDN: if (w_tmr_done) begin
                w_state_nxt = S_RST;
                w_tmr_load  = 1'b1;
                w_tmr_cyc   = c_RST_VAL;
            end
            S_RST: if (w_tmr_done) begin
                w_state_nxt = S_BOOT;
                w_tmr_load  = 1'b1;
                w_tmr_cyc   = c_BOOT_VAL;
            end
            S_BOOT:  if (w_tmr_done) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_e'(rom_q[OP_HI:OP_LO]))
                    OP_END:   w_state_nxt = S_DONE;
                    OP_DELAY: begin
                        w_state_nxt = S_DLY;
                        w_tmr_load  = 1'b1;
                        w_tmr_ms    = 1'b1;
                    end
                    default:  w_state_nxt = S_REQ;
                endcase
            end
            S_REQ: w_state_nxt = S_WAIT;
            // A NACK consumes a retry; an acked read that misses consumes a poll attempt.
            S_WAIT: if (RW_Done) begin
                if (ack) begin
                    if (r_retry == c_RETRY_LAST) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else if ((r_op == OP_POLL) && !w_match) begin
                    if (r_poll == c_POLL_LAST) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_poll_inc  = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_DLY: if (w_tmr_done) w_advance = 1'b1;
            S_DONE, S_ERR: if (Start) begin
                w_state_nxt = S_PWDN;
                w_tmr_load  = 1'b1;
                w_tmr_cyc   = c_PWDN_VAL;
            end
            default: w_state_nxt = S_PWDN;
        endcase
        if (w_advance) w_state_nxt = (&r_rom_addr) ? S_DONE : S_FETCH;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_PWDN;
            r_op        <= OP_WRITE;
            r_rom_addr  <= '0;
            r_err_index <= '0;
            r_reg_addr  <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_retry     <= '0;
            r_poll      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_BOOT) && w_tmr_done) begin
                r_rom_addr <= '0;
            end else if (w_advance && !(&r_rom_addr)) begin
                r_rom_addr <= r_rom_addr + 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_op       <= op_e'(rom_q[OP_HI:OP_LO]);
                r_reg_addr <= w_dec_addr;
                r_data     <= rom_q[DATA_HI:DATA_LO];
                r_mask     <= rom_q[MASK_HI:MASK_LO];
            end
            if (w_advance || (r_state == S_DECODE)) begin
                r_retry <= '0;
                r_poll  <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end else if (w_poll_inc) begin
                r_poll  <= r_poll + 1'b1;
                r_retry <= '0;
            end
            if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) r_err_index <= r_rom_addr;
        end
    end

    assign camera_pwdn  = (r_state == S_PWDN);
    assign camera_rst_n = !((r_state == S_PWDN) || (r_state == S_RST));
    assign wrreg_req    = (r_state == S_REQ) && (r_op == OP_WRITE);
    assign rdreg_req    = (r_state == S_REQ) && (r_op == OP_POLL);
    assign rom_addr     = r_rom_addr;
    assign addr_mode    = ADDR16;
    assign device_id    = DEVICE_ID;
    assign reg_addr     = r_reg_addr;
    assign wrdata       = r_data;
    assign Init_Done    = (r_state == S_DONE);
    assign Init_Err     = (r_state == S_ERR);
    assign err_index    = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_sensor_reg_seq.sv
`default_nettype none
// ============================================================================
// tb_sensor_reg_seq : randomized self-checking bench with an I2C responder and table model
// Rev 1.0
// ============================================================================
module tb_sensor_reg_seq;

    localparam int c_AW    = 4;
    localparam int c_DEPTH = 1 << c_AW;
    localparam int c_RETRY = 3;
    localparam int c_POLL  = 4;

    typedef struct packed {
        logic        rd;
        logic [15:0] a;
        logic [7:0]  d;
    } txn_t;

    logic              Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0;
    logic              camera_pwdn, camera_rst_n, wrreg_req, rdreg_req, addr_mode;
    logic              RW_Done = 1'b0, ack = 1'b0, Init_Done, Init_Err;
    logic [c_AW-1:0]   rom_addr, err_index;
    logic [33:0]       rom_q = '0;
    logic [7:0]        device_id, wrdata, rddata = 8'h00;
    logic [15:0]       reg_addr;
    logic [33:0]       rom [c_DEPTH];

    int   n_checks = 0, n_fail = 0;
    txn_t obs_q[$], exp_q[$];
    bit   exp_err;
    int   exp_idx;
    int   scr_nack_first, nack_left;
    bit   scr_nack_all;
    logic [7:0] scr_rd[$], live_rd[$];
    int   long_pulse = 0, overlap = 0;
    int   t_pwdn, t_rstn, t_req;
    int   t_addr [c_DEPTH];

    sensor_reg_seq #(
        .DEVICE_ID (8'h78), .ADDR16 (1'b1), .ROM_AW (c_AW),
        .PWDN_CYC (16), .RST_CYC (8), .BOOT_CYC (32), .MS_CYC (10),
        .MAX_RETRY (c_RETRY), .POLL_MAX (c_POLL)
    ) dut (
        .Clk (Clk), .Rst_n (Rst_n), .Start (Start),
        .camera_pwdn (camera_pwdn), .camera_rst_n (camera_rst_n),
        .rom_addr (rom_addr), .rom_q (rom_q),
        .wrreg_req (wrreg_req), .rdreg_req (rdreg_req),
        .addr_mode (addr_mode), .device_id (device_id),
        .reg_addr (reg_addr), .wrdata (wrdata), .rddata (rddata),
        .RW_Done (RW_Done), .ack (ack),
        .Init_Done (Init_Done), .Init_Err (Init_Err), .err_index (err_index)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_q <= rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // I2C responder: random latency, scripted NACKs, scripted read data
    initial begin
        int  lat;
        bit  pend, pend_rd;
        pend = 0; pend_rd = 0; lat = 0;
        forever begin
            @(posedge Clk); #1;
            RW_Done = 1'b0;
            ack     = 1'b0;
            if (pend && (wrreg_req || rdreg_req)) overlap++;
            if (!Rst_n) begin
                pend = 0;
            end else if (pend) begin
                if (lat == 0) begin
                    pend    = 0;
                    RW_Done = 1'b1;
                    if (scr_nack_all || nack_left > 0) begin
                        ack = 1'b1;
                        if (nack_left > 0) nack_left--;
                    end else if (pend_rd) begin
                        rddata = (live_rd.size() > 0) ? live_rd.pop_front() : 8'h00;
                    end
                end else begin
                    lat--;
                end
            end else if (wrreg_req || rdreg_req) begin
                obs_q.push_back('{rd: rdreg_req, a: reg_addr, d: wrdata});
                pend    = 1;
                pend_rd = rdreg_req;
                lat     = $urandom_range(1, 4);
            end
        end
    end

    initial begin
        bit pw, pr;
        pw = 0; pr = 0;
        forever begin
            @(posedge Clk); #1;
            if ((wrreg_req && pw) || (rdreg_req && pr)) long_pulse++;
            pw = wrreg_req;
            pr = rdreg_req;
        end
    end

    function automatic logic [33:0] mk(input logic [1:0] op, input logic [15:0] a,
                                       input logic [7:0] d, input logic [7:0] m);
        return {op, a, d, m};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < c_DEPTH; i++) rom[i] = mk(2'b11, 16'h0, 8'h0, 8'h0);
    endtask

    task automatic load_script(input int nf, input bit all);
        scr_nack_first = nf;
        scr_nack_all   = all;
        nack_left      = nf;
        live_rd        = scr_rd;
    endtask

    // Walks the table at command level and predicts every I2C transaction and the final status.
    task automatic build_expect();
        int idx, nl, fails, misses;
        bit ok;
        logic [33:0] c;
        logic [7:0]  v;
        logic [7:0]  rq[$];
        idx = 0; nl = scr_nack_first; rq = scr_rd;
        exp_q.delete(); exp_err = 0; exp_idx = 0;
        forever begin
            c = rom[idx];
            if (c[33:32] == 2'b11) break;
            if (c[33:32] != 2'b01) begin
                fails = 0; misses = 0; ok = 0;
                while (!ok && !exp_err) begin
                    exp_q.push_back('{rd: (c[33:32] == 2'b10), a: c[31:16], d: c[15:8]});
                    if (scr_nack_all || nl > 0) begin
                        if (nl > 0) nl--;
                        fails++;
                        if (fails > c_RETRY) exp_err = 1;
                    end else if (c[33:32] == 2'b00) begin
                        ok = 1;
                    end else begin
                        v = (rq.size() > 0) ? rq.pop_front() : 8'h00;
                        if ((v & c[7:0]) == (c[15:8] & c[7:0])) ok = 1;
                        else begin
                            misses++;
                            fails = 0;
                            if (misses >= c_POLL) exp_err = 1;
                        end
                    end
                end
                if (exp_err) begin
                    exp_idx = idx;
                    break;
                end
            end
            if (idx == c_DEPTH - 1) break;
            idx++;
        end
    endtask

    task automatic enter_reset();
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
    endtask

    task automatic release_reset();
        obs_q.delete();
        Rst_n = 1'b1;
    endtask

    task automatic run_seq(input int budget);
        int n;
        logic [c_AW-1:0] prev;
        n = 0; t_pwdn = -1; t_rstn = -1; t_req = -1; prev = rom_addr;
        for (int i = 0; i < c_DEPTH; i++) t_addr[i] = -1;
        while (!(Init_Done || Init_Err) && n < budget) begin
            @(posedge Clk); #1;
            n++;
            if (t_pwdn < 0 && !camera_pwdn) t_pwdn = n;
            if (t_rstn < 0 && camera_rst_n) t_rstn = n;
            if (t_req < 0 && (wrreg_req || rdreg_req)) t_req = n;
            if (rom_addr != prev) begin
                t_addr[rom_addr] = n;
                prev = rom_addr;
            end
        end
        check_eq("seq_ends_within_budget", 32'(n < budget), 32'd1);
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic compare_run(input string tag);
        check_eq({tag, "_txn_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq($sformatf("%s_txn%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_done"}, Init_Done, !exp_err);
        check_eq({tag, "_err"}, Init_Err, exp_err);
        if (exp_err) check_eq({tag, "_err_index"}, err_index, exp_idx);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pwdn"}, camera_pwdn, 1'b1);
        check_eq({tag, "_rst_n"}, camera_rst_n, 1'b0);
        check_eq({tag, "_wrreg"}, wrreg_req, 1'b0);
        check_eq({tag, "_rdreg"}, rdreg_req, 1'b0);
        check_eq({tag, "_done"}, Init_Done, 1'b0);
        check_eq({tag, "_err"}, Init_Err, 1'b0);
        check_eq({tag, "_err_index"}, err_index, '0);
        check_eq({tag, "_rom_addr"}, rom_addr, '0);
        check_eq({tag, "_reg_addr"}, reg_addr, 16'h0);
        check_eq({tag, "_wrdata"}, wrdata, 8'h0);
    endtask

    task automatic pulse_start();
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic fresh_run(input string tag, input int nf, input bit all);
        enter_reset();
        load_script(nf, all);
        build_expect();
        release_reset();
        run_seq(4000);
        compare_run(tag);
    endtask

    initial begin
        int n, pulses;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("por");
        check_eq("device_id", device_id, 8'h78);
        check_eq("addr_mode", addr_mode, 1'b1);

        // basic table, also used for the power-up timing
        clear_rom();
        rom[0] = mk(2'b00, 16'h3008, 8'h82, 8'h00);
        rom[1] = mk(2'b00, 16'h3103, 8'h11, 8'h00);
        scr_rd.delete();
        fresh_run("basic", 0, 0);
        check_eq("pwdn_fall_cycle", t_pwdn, 16);
        check_eq("rst_n_rise_cycle", t_rstn, 24);
        check_eq("first_req_cycle", t_req, 58);

        // Start in DONE replays; Start during BOOT is ignored
        load_script(0, 0);
        obs_q.delete();
        pulse_start();
        check_eq("start_clears_done", Init_Done, 1'b0);
        check_eq("start_pwdn_reasserts", camera_pwdn, 1'b1);
        n = 0;
        while (!camera_rst_n && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        check_eq("reach_boot", camera_rst_n, 1'b1);
        pulse_start();
        check_eq("midseq_start_pwdn", camera_pwdn, 1'b0);
        check_eq("midseq_start_rst_n", camera_rst_n, 1'b1);
        run_seq(4000);
        compare_run("replay");

        // randomized write tables with a few leading NACKs
        for (int it = 0; it < 3; it++) begin
            clear_rom();
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++)
                rom[i] = mk(2'b00, 16'($urandom), 8'($urandom), 8'h00);
            fresh_run($sformatf("rand%0d", it), $urandom_range(0, 3), 0);
        end

        // DELAY 5 ms at 10 clocks/ms
        clear_rom();
        rom[0] = mk(2'b00, 16'h1234, 8'h56, 8'h00);
        rom[1] = mk(2'b01, 16'h0000, 8'h00, 8'h05);
        rom[2] = mk(2'b00, 16'h4321, 8'h65, 8'h00);
        fresh_run("delay", 0, 0);
        n = t_addr[2] - t_addr[1] - 1;
        check_eq("delay_from_decode", 32'((n >= 48) && (n <= 52)), 32'd1);

        // two NACKs then ack: three pulses on the first write
        clear_rom();
        rom[0] = mk(2'b00, 16'h3008, 8'h82, 8'h00);
        rom[1] = mk(2'b00, 16'h3103, 8'h11, 8'h00);
        fresh_run("nack2", 2, 0);

        // always NACK behind a zero-length delay: error at entry 1
        clear_rom();
        rom[0] = mk(2'b01, 16'h0000, 8'h00, 8'h00);
        rom[1] = mk(2'b00, 16'h5a5a, 8'h33, 8'h00);
        fresh_run("nack_all", 0, 1);

        // restart from ERR, then reset while waiting on the second write
        clear_rom();
        rom[0] = mk(2'b00, 16'h0101, 8'h11, 8'h00);
        rom[1] = mk(2'b00, 16'h0202, 8'h22, 8'h00);
        rom[2] = mk(2'b00, 16'h0303, 8'h33, 8'h00);
        load_script(0, 0);
        pulse_start();
        pulses = 0; n = 0;
        while (pulses < 2 && n < 1000) begin
            @(posedge Clk); #1;
            n++;
            if (wrreg_req) pulses++;
        end
        check_eq("reach_second_write", pulses, 2);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check_reset_vals("rst_in_wait");
        fresh_run("after_rst", 0, 0);

        // POLL matching on the third read
        clear_rom();
        rom[0] = mk(2'b10, 16'h300a, 8'h56, 8'hff);
        rom[1] = mk(2'b00, 16'h3103, 8'h11, 8'h00);
        scr_rd = '{8'h00, 8'h00, 8'h56};
        fresh_run("poll_hit", 0, 0);

        // POLL never matching
        scr_rd.delete();
        fresh_run("poll_miss", 0, 0);

        // full table without END stops after the last entry
        clear_rom();
        for (int i = 0; i < c_DEPTH; i++)
            rom[i] = mk(2'b00, 16'($urandom), 8'($urandom), 8'h00);
        fresh_run("full_rom", 0, 0);

        check_eq("req_pulse_width", long_pulse, 0);
        check_eq("one_outstanding", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
